alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have no parameters; operand width is fixed at 8 bits.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req_valid / req_ready  input / output  1 / 1  command handshake; a transfer occurs on an edge where both are 1.
REQ-005 req_cmd / req_a / req_b  input  4 / 8 / 8  command code, operand A, operand B.
REQ-006 alu_op / alu_right / alu_ci / alu_bcd / alu_rdy  output  4/1/1/1/1  drive the ALU op, right, CI, BCD and RDY pins.
REQ-007 alu_ai / alu_bi  output  8 / 8  drive the ALU AI and BI pins.
REQ-008 alu_out / alu_co / alu_v / alu_z / alu_n  input  8/1/1/1/1  registered ALU result and flags.
REQ-009 rsp_valid / rsp_ready / rsp_data  output / input / output  1/1/8  result handshake and data.
REQ-010 p_c / p_z / p_v / p_n / p_d  output  1 each  status flags held by this block.

Function
REQ-011 States SHALL be IDLE, ISSUE, CAPTURE and RESP; req_ready SHALL be 1 only in IDLE.
REQ-012 Accepting an ALU command SHALL move IDLE->ISSUE, latching cmd, A and B.
REQ-013 Accepting a flag command (C..F) SHALL move IDLE->RESP directly, with no ALU activity.
REQ-014 In ISSUE, alu_rdy SHALL be 1 for exactly one cycle; state then moves to CAPTURE.
REQ-015 alu_rdy SHALL be 0 in every other state, so the ALU holds its outputs.
REQ-016 In CAPTURE, the block SHALL latch alu_out into rsp_data, update the flags per REQ-018, and go to RESP.
REQ-017 In RESP, rsp_valid SHALL be 1 and rsp_data stable until rsp_ready=1, then return to IDLE; no new command is accepted that edge.
REQ-018 Command mapping (cmd: op/right/ci/bi; flags updated), with alu_ai=A and alu_bcd=0 unless stated:
- 0 ADC: 0011/0/p_c/B; NVZC; bcd=p_d
- 1 SBC: 0111/0/p_c/B; NVZC; bcd=p_d
- 2 CMP: 0111/0/1/B; NZC
- 3 ORA, 4 AND, 5 EOR: 1100, 1101, 1110 /0/0/B; NZ
- 6 ASL: 1011/0/0/B; NZC
- 7 ROL: 1011/0/p_c/B; NZC
- 8 LSR: 1111/1/0/B; NZC
- 9 ROR: 1111/1/p_c/B; NZC
- A INC: 0011/0/1/0x00; NZ
- B DEC: 0111/0/0/0x00; NZ
- C SEC, D CLC, E SED, F CLD: only the named flag changes; rsp_data = A
REQ-019 Flag sources SHALL be: C=alu_co, N=alu_n, Z=alu_z, V=alu_v; flags not listed for a command SHALL hold.
REQ-020 ci SHALL use p_c as sampled in ISSUE.
REQ-021 ALU command latency SHALL be 3 edges from accept to rsp_valid=1; flag commands SHALL take 1 edge.
REQ-022 Outside ISSUE, ALU-side outputs SHALL keep the values driven in the last ISSUE cycle.

Reset
REQ-023 While reset=1, the block SHALL go to IDLE and clear rsp_valid, rsp_data, p_c/p_z/p_v/p_n/p_d, and all alu_* outputs.
REQ-024 Reset SHALL take priority over any handshake in the same cycle; a command in flight is discarded with no response.

Configuration
REQ-025 With ALU_SEQ_DECIMAL_EN defined, SED/CLD SHALL control p_d and ADC/SBC SHALL drive alu_bcd=p_d.
REQ-026 With ALU_SEQ_DECIMAL_EN undefined, p_d and alu_bcd SHALL be constant 0; SED/CLD still complete with a normal response.

Verification
REQ-027 Reset, CLC, then ADC A=0x50 B=0x50 -> in ISSUE alu_op=0011, ci=0, bcd=0; rsp_valid on 3rd edge after accept; with ALU model rsp_data=0xA0, N=1, V=1, Z=0, C=0.
REQ-028 SEC, then SBC A=0x00 B=0x01 -> rsp_data=0xFF, C=0, N=1, Z=0.
REQ-029 CMP A=0x42 B=0x42 -> Z=1, C=1, N=0; V unchanged from its prior value.
REQ-030 SEC, then ROR A=0x02 -> alu_right=1, ci=1; rsp_data=0x81, C=0, N=1.
REQ-031 INC A=0xFF with rsp_ready held 0 for 5 cycles -> rsp_data=0x00, Z=1; rsp_valid and data stable; req_ready=0 throughout; IDLE on the edge after rsp_ready=1.
REQ-032 Assert reset in CAPTURE -> no response, all flags 0, req_ready=1 on the next cycle.
REQ-033 SED then ADC, with and without ALU_SEQ_DECIMAL_EN -> alu_bcd=1 and 0 respectively.

Source files
------------

// File: rtl/alu_seq_if.sv
// alu_seq_if: command request and result response handshake bundle for alu_seq.
interface alu_seq_if;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_cmd;
  logic [7:0] req_a;
  logic [7:0] req_b;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  modport master (
    output req_valid, req_cmd, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );
  modport slave (
    input  req_valid, req_cmd, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: sequences commands onto a registered ALU and holds its flags; ALU_SEQ_DECIMAL_EN enables the decimal flag.
module alu_seq (
  input  logic       clk,
  input  logic       reset,
  alu_seq_if.slave   bus,
  output logic [3:0] alu_op,
  output logic       alu_right,
  output logic       alu_ci,
  output logic       alu_bcd,
  output logic       alu_rdy,
  output logic [7:0] alu_ai,
  output logic [7:0] alu_bi,
  input  logic [7:0] alu_out,
  input  logic       alu_co,
  input  logic       alu_v,
  input  logic       alu_z,
  input  logic       alu_n,
  output logic       p_c,
  output logic       p_z,
  output logic       p_v,
  output logic       p_n,
  output logic       p_d
);
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;
  state_t     state_q, state_d;
  logic [3:0] cmd_q, cmd_d, op_q, op_d;
  logic [7:0] ai_q, ai_d, bi_q, bi_d, data_q, data_d;
  logic       right_q, right_d, ci_q, ci_d, bcd_q, bcd_d, rdy_q, rdy_d;
  logic       c_q, c_d, z_q, z_d, v_q, v_d, n_q, n_d, d_q, d_d;
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    op_d    = op_q;
    ai_d    = ai_q;
    bi_d    = bi_q;
    right_d = right_q;
    ci_d    = ci_q;
    bcd_d   = bcd_q;
    rdy_d   = 1'b0;
    data_d  = data_q;
    c_d     = c_q;
    z_d     = z_q;
    v_d     = v_q;
    n_d     = n_q;
`ifdef ALU_SEQ_DECIMAL_EN
    d_d     = d_q;
`else
    d_d     = 1'b0;
`endif
    case (state_q)
      IDLE: if (bus.req_valid) begin
        cmd_d = bus.req_cmd;
        if (bus.req_cmd < 4'hC) begin
          state_d = ISSUE;
          rdy_d   = 1'b1;
          ai_d    = bus.req_a;
          bi_d    = bus.req_cmd >= 4'hA ? 8'h00 : bus.req_b;
          right_d = bus.req_cmd inside {4'h8, 4'h9};
          ci_d    = bus.req_cmd inside {4'h0, 4'h1, 4'h7, 4'h9} ? c_q : bus.req_cmd inside {4'h2, 4'hA};
          bcd_d   = bus.req_cmd < 4'h2 ? d_q : 1'b0;
          case (bus.req_cmd)
            4'h0, 4'hA:       op_d = 4'b0011;
            4'h3:             op_d = 4'b1100;
            4'h4:             op_d = 4'b1101;
            4'h5:             op_d = 4'b1110;
            4'h6, 4'h7:       op_d = 4'b1011;
            4'h8, 4'h9:       op_d = 4'b1111;
            default:          op_d = 4'b0111;
          endcase
        end else begin
          state_d = RESP;
          data_d  = bus.req_a;
          c_d     = bus.req_cmd == 4'hC ? 1'b1 : bus.req_cmd == 4'hD ? 1'b0 : c_q;
`ifdef ALU_SEQ_DECIMAL_EN
          d_d     = bus.req_cmd == 4'hE ? 1'b1 : bus.req_cmd == 4'hF ? 1'b0 : d_q;
`endif
        end
      end
      ISSUE: state_d = CAPTURE;
      CAPTURE: begin
        state_d = RESP;
        data_d  = alu_out;
        n_d     = alu_n;
        z_d     = alu_z;
        c_d     = cmd_q inside {4'h3, 4'h4, 4'h5, 4'hA, 4'hB} ? c_q : alu_co;
        v_d     = cmd_q < 4'h2 ? alu_v : v_q;
      end
      RESP: state_d = bus.rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      op_q    <= '0;
      ai_q    <= '0;
      bi_q    <= '0;
      right_q <= 1'b0;
      ci_q    <= 1'b0;
      bcd_q   <= 1'b0;
      rdy_q   <= 1'b0;
      data_q  <= '0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      v_q     <= 1'b0;
      n_q     <= 1'b0;
      d_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      op_q    <= op_d;
      ai_q    <= ai_d;
      bi_q    <= bi_d;
      right_q <= right_d;
      ci_q    <= ci_d;
      bcd_q   <= bcd_d;
      rdy_q   <= rdy_d;
      data_q  <= data_d;
      c_q     <= c_d;
      z_q     <= z_d;
      v_q     <= v_d;
      n_q     <= n_d;
      d_q     <= d_d;
    end
  end
  assign bus.req_ready = state_q == IDLE;
  assign bus.rsp_valid = state_q == RESP;
  assign bus.rsp_data  = data_q;
  assign alu_op    = op_q;
  assign alu_right = right_q;
  assign alu_ci    = ci_q;
  assign alu_bcd   = bcd_q;
  assign alu_rdy   = rdy_q;
  assign alu_ai    = ai_q;
  assign alu_bi    = bi_q;
  assign p_c = c_q;
  assign p_z = z_q;
  assign p_v = v_q;
  assign p_n = n_q;
  assign p_d = d_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq with a behavioural registered ALU on its pins.
module tb_alu_seq;
`ifdef ALU_SEQ_DECIMAL_EN
  localparam logic DEC = 1'b1;
`else
  localparam logic DEC = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1;
  logic [3:0] alu_op;
  logic       alu_right, alu_ci, alu_bcd, alu_rdy;
  logic [7:0] alu_ai, alu_bi, alu_out;
  logic       alu_co, alu_v, alu_z, alu_n;
  logic       p_c, p_z, p_v, p_n, p_d;
  int n_cmp = 0, n_err = 0;
  logic m_c = 0, m_z = 0, m_v = 0, m_n = 0, m_d = 0;
  logic [3:0] last_op;
  logic       last_right, last_ci, last_bcd;
  typedef struct packed {logic [7:0] data; logic n, v, z, c, d;} sb_t;
  sb_t sb[$];
  alu_seq_if bus();
  alu_seq dut (
    .clk(clk), .reset(reset), .bus(bus),
    .alu_op(alu_op), .alu_right(alu_right), .alu_ci(alu_ci), .alu_bcd(alu_bcd), .alu_rdy(alu_rdy),
    .alu_ai(alu_ai), .alu_bi(alu_bi), .alu_out(alu_out), .alu_co(alu_co), .alu_v(alu_v),
    .alu_z(alu_z), .alu_n(alu_n), .p_c(p_c), .p_z(p_z), .p_v(p_v), .p_n(p_n), .p_d(p_d)
  );
  always #5 clk = ~clk;
  function automatic logic [11:0] pin_alu(input logic [3:0] op, input logic right, ci, input logic [7:0] a, b);
    logic [7:0] bb, r;
    logic [8:0] s;
    logic co, v;
    bb = op == 4'b0111 ? ~b : b;
    s  = {1'b0, a} + {1'b0, bb} + {8'b0, ci};
    r  = s[7:0];
    co = 1'b0;
    v  = 1'b0;
    case (op)
      4'b0011, 4'b0111: begin co = s[8]; v = (a[7] == bb[7]) && (r[7] != a[7]); end
      4'b1100: r = a | b;
      4'b1101: r = a & b;
      4'b1110: r = a ^ b;
      4'b1011: begin r = {a[6:0], ci}; co = a[7]; end
      4'b1111: begin r = right ? {ci, a[7:1]} : a; co = a[0]; end
      default: r = 8'h00;
    endcase
    return {co, v, r == 8'h00, r[7], r};
  endfunction
  always @(posedge clk) begin
    if (reset) {alu_co, alu_v, alu_z, alu_n, alu_out} <= '0;
    else if (alu_rdy) {alu_co, alu_v, alu_z, alu_n, alu_out} <= pin_alu(alu_op, alu_right, alu_ci, alu_ai, alu_bi);
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic model(input logic [3:0] cmd, input logic [7:0] a, b, output logic [7:0] r);
    logic [8:0] s;
    s = '0;
    case (cmd)
      4'h0: begin s = {1'b0, a} + {1'b0, b} + {8'b0, m_c}; r = s[7:0]; m_v = (a[7] == b[7]) && (r[7] != a[7]); m_c = s[8]; end
      4'h1: begin s = {1'b0, a} + {1'b0, ~b} + {8'b0, m_c}; r = s[7:0]; m_v = (a[7] != b[7]) && (r[7] != a[7]); m_c = s[8]; end
      4'h2: begin r = a - b; m_c = a >= b; end
      4'h3: r = a | b;
      4'h4: r = a & b;
      4'h5: r = a ^ b;
      4'h6: begin r = {a[6:0], 1'b0}; m_c = a[7]; end
      4'h7: begin r = {a[6:0], m_c}; m_c = a[7]; end
      4'h8: begin r = {1'b0, a[7:1]}; m_c = a[0]; end
      4'h9: begin r = {m_c, a[7:1]}; m_c = a[0]; end
      4'hA: r = a + 8'd1;
      4'hB: r = a - 8'd1;
      default: r = a;
    endcase
    if (cmd < 4'hC) begin m_z = r == 8'h00; m_n = r[7]; end
    if (cmd == 4'hC) m_c = 1'b1;
    if (cmd == 4'hD) m_c = 1'b0;
    if (DEC && cmd == 4'hE) m_d = 1'b1;
    if (DEC && cmd == 4'hF) m_d = 1'b0;
  endtask
  task automatic do_cmd(input logic [3:0] cmd, input logic [7:0] a, b, input int stall);
    sb_t e, g;
    int n, edges;
    logic [7:0] snap;
    n = 0;
    while (!bus.req_ready && n < 20) begin @(posedge clk); #1; n++; end
    check("req_ready_wait", bus.req_ready, 1);
    bus.req_valid = 1'b1; bus.req_cmd = cmd; bus.req_a = a; bus.req_b = b;
    bus.rsp_ready = stall == 0;
    model(cmd, a, b, e.data);
    e.n = m_n; e.v = m_v; e.z = m_z; e.c = m_c; e.d = m_d;
    sb.push_back(e);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("issue_rdy", alu_rdy, cmd < 4'hC);
    last_op = alu_op; last_right = alu_right; last_ci = alu_ci; last_bcd = alu_bcd;
    edges = 1;
    while (!bus.rsp_valid && edges < 10) begin
      @(posedge clk); #1; edges++;
      if (edges == 2) check("rdy_pulse", alu_rdy, 0);
    end
    check("latency", edges, cmd < 4'hC ? 3 : 1);
    snap = bus.rsp_data;
    for (int i = 0; i < stall; i++) begin
      check("stall_hold", {bus.rsp_valid, bus.req_ready, bus.rsp_data}, {2'b10, snap});
      @(posedge clk); #1;
    end
    bus.rsp_ready = 1'b1;
    if (sb.size() == 0) check("sb_underflow", 1, 0);
    else begin
      g = sb.pop_front();
      check("rsp_data", bus.rsp_data, g.data);
      check("flags_nvzcd", {p_n, p_v, p_z, p_c, p_d}, {g.n, g.v, g.z, g.c, g.d});
    end
    @(posedge clk); #1;
    check("idle_after", {bus.req_ready, bus.rsp_valid}, 2'b10);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end
  initial begin
    bus.req_valid = 1'b0; bus.req_cmd = '0; bus.req_a = '0; bus.req_b = '0; bus.rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_hs", {bus.req_ready, bus.rsp_valid, bus.rsp_data}, {2'b10, 8'h00});
    check("reset_flags", {p_c, p_z, p_v, p_n, p_d}, 0);
    check("reset_alu", {alu_op, alu_right, alu_ci, alu_bcd, alu_rdy, alu_ai, alu_bi}, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    do_cmd(4'hD, 8'h00, 8'h00, 0);
    do_cmd(4'h0, 8'h50, 8'h50, 0);
    check("adc_pins", {last_op, last_ci, last_bcd}, {4'b0011, 2'b00});
    check("adc_result", {bus.rsp_data, p_n, p_v, p_z, p_c}, {8'hA0, 4'b1100});
    do_cmd(4'h2, 8'h42, 8'h42, 0);
    check("cmp_v_hold", {p_z, p_c, p_n, p_v}, 4'b1101);
    do_cmd(4'hC, 8'h00, 8'h00, 0);
    do_cmd(4'h1, 8'h00, 8'h01, 0);
    check("sbc_result", {p_c, p_n, p_z}, 3'b010);
    do_cmd(4'hC, 8'h00, 8'h00, 0);
    do_cmd(4'h9, 8'h02, 8'h00, 0);
    check("ror_pins", {last_right, last_ci}, 2'b11);
    do_cmd(4'hA, 8'hFF, 8'h00, 5);
    for (int i = 0; i < 24; i++)
      do_cmd(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), i % 3);
    do_cmd(4'hE, 8'h00, 8'h00, 0);
    do_cmd(4'h0, 8'h15, 8'h27, 0);
    check("adc_bcd_pin", last_bcd, DEC);
    do_cmd(4'hF, 8'h00, 8'h00, 0);
    do_cmd(4'h0, 8'h15, 8'h27, 0);
    check("adc_nobcd_pin", last_bcd, 0);
    do_cmd(4'hC, 8'h00, 8'h00, 0);
    bus.req_valid = 1'b1; bus.req_cmd = 4'h0; bus.req_a = 8'h10; bus.req_b = 8'h20;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst_capture", {bus.req_ready, bus.rsp_valid, p_c, p_z, p_v, p_n, p_d}, 7'b1000000);
    check("rst_capture_alu", {alu_op, alu_right, alu_ci, alu_bcd, alu_rdy, alu_ai, alu_bi}, 0);
    m_c = 0; m_z = 0; m_v = 0; m_n = 0; m_d = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.rsp_valid) check("rst_no_resp", bus.rsp_valid, 0);
      @(posedge clk); #1;
    end
    do_cmd(4'h4, 8'hF0, 8'h3C, 0);
    check("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
